sk9822_chain: RTL and testbench

- Parametrised SK9822/APA102 LED-chain driver on the Wishbone data bus.
- CPU writes per-LED words into an internal RAM and sets a control register. The block then serialises complete frames (start frame, LED words, end frame) on led_ck/led_data.
- Successor to the fixed 12-LED driver. Adds variable chain length, datasheet-sized end frame, one-shot/continuous modes, global brightness override and status readback.

---
 rtl/sk9822_chain.sv | 165 ++++++++++++++++
 tb/tb_sk9822_chain.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sk9822_chain.sv
// sk9822_chain: Wishbone-mapped SK9822/APA102 chain driver.
// It holds per-LED words in a RAM and serialises start/LED/end frames in one-shot or continuous mode.
module sk9822_chain #(
    parameter logic [7:0] ADDR     = 8'h00,
    parameter int         LEDS     = 12,
    parameter int         PRESCALE = 4,
    parameter int         GAP      = 1
) (
    input  logic        wb_clk,
    input  logic        wb_rst,
    input  logic        wb_dbus_cyc,
    input  logic        wb_dbus_we,
    input  logic [31:0] wb_dbus_adr,
    input  logic [31:0] wb_dbus_dat,
    output logic [31:0] wb_dbus_rdt,
    output logic        ack,
    output logic        led_ck,
    output logic        led_data
);
    typedef enum logic [2:0] {S_IDLE, S_START, S_PIXEL, S_END, S_GAP} state_t;

    localparam int                  IW       = $clog2(LEDS + 1);
    localparam logic [6:0]          NLEDS    = 7'(LEDS);
    localparam logic [IW-1:0]       LAST_IDX = IW'(LEDS - 1);
    localparam logic [3:0]          END_LAST = 4'((LEDS + 63) / 64 - 1);
    localparam logic [3:0]          GAP_LAST = 4'(GAP > 0 ? GAP - 1 : 0);
    localparam logic [PRESCALE-1:0] HALF     = {1'b1, {(PRESCALE - 1){1'b0}}};

    logic [31:0]         ram [64];
    logic                ack_q, ack_d;
    logic                en_q, en_d, cont_q, cont_d, ovr_q, ovr_d;
    logic                go_q, go_d, done_q, done_d;
    logic [4:0]          bri_q, bri_d;
    logic [PRESCALE-1:0] pre_q;
    state_t              state_q, state_d;
    logic [4:0]          bcnt_q, bcnt_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [3:0]          wcnt_q, wcnt_d;
    logic [31:0]         sh_q, sh_d;
    logic                ck_q, ck_d, data_q, data_d;

    logic        hit, wr, in_ram, ram_we, ctrl_we, stat_we;
    logic [5:0]  widx;
    logic [31:0] ctrl_rd, stat_rd, rd;
    logic        tick, last_bit, go_take, done_set, ld;
    logic [6:0]  ld_idx;
    logic [31:0] rw;
    logic        unused_bits;

    assign tick     = pre_q == '0;
    assign ack      = ack_q;
    assign led_ck   = ck_q;
    assign led_data = data_q;

    // Bus side: ack follows a hit by one cycle; accesses complete in the ack cycle.
    always_comb begin
        hit         = wb_dbus_cyc && wb_dbus_adr[31:24] == ADDR;
        ack_d       = hit && !ack_q;
        widx        = wb_dbus_adr[7:2];
        in_ram      = !wb_dbus_adr[8] && {1'b0, widx} < NLEDS;
        wr          = ack_q && wb_dbus_we;
        ram_we      = wr && in_ram;
        ctrl_we     = wr && wb_dbus_adr[8] && widx == 6'd0;
        stat_we     = wr && wb_dbus_adr[8] && widx == 6'd1;
        ctrl_rd     = {18'd0, ovr_q, bri_q, 6'd0, cont_q, en_q};
        stat_rd     = {30'd0, done_q, state_q != S_IDLE};
        rd          = in_ram ? ram[widx] : !wb_dbus_adr[8] ? 32'd0 :
                      widx == 6'd0 ? ctrl_rd : widx == 6'd1 ? stat_rd : 32'd0;
        wb_dbus_rdt = ack_q ? rd : 32'd0;
    end

    always_comb begin
        en_d   = ctrl_we ? wb_dbus_dat[0] : en_q;
        cont_d = ctrl_we ? wb_dbus_dat[1] : cont_q;
        bri_d  = ctrl_we ? wb_dbus_dat[12:8] : bri_q;
        ovr_d  = ctrl_we ? wb_dbus_dat[13] : ovr_q;
        go_d   = (go_q && !go_take) || (ctrl_we && wb_dbus_dat[2]);
        done_d = done_set || (done_q && !(stat_we && wb_dbus_dat[1]));
    end

    always_comb begin
        state_d  = state_q;
        last_bit = bcnt_q == 5'd31;
        if (tick) begin
            case (state_q)
                S_IDLE:  if (en_q && (cont_q || go_q)) state_d = S_START;
                S_START: if (last_bit) state_d = S_PIXEL;
                S_PIXEL: if (last_bit && idx_q == LAST_IDX) state_d = S_END;
                S_END:   if (last_bit && wcnt_q == END_LAST)
                             state_d = (en_q && cont_q) ? (GAP > 0 ? S_GAP : S_START) : S_IDLE;
                S_GAP:   if (last_bit && wcnt_q == GAP_LAST) state_d = en_q ? S_START : S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
        go_take  = tick && state_q == S_IDLE && state_d == S_START;
        done_set = tick && state_q == S_END && last_bit && wcnt_q == END_LAST;
    end

    // Each LED word is fetched at its first bit, so RAM writes mid-word only affect later words.
    always_comb begin
        bcnt_d = bcnt_q;
        idx_d  = idx_q;
        wcnt_d = wcnt_q;
        sh_d   = sh_q;
        ck_d   = ck_q;
        data_d = data_q;
        idx_d  = state_d != S_PIXEL ? '0 : (state_q == S_PIXEL && last_bit) ? idx_q + 1'b1 : idx_q;
        ld     = state_d == S_PIXEL && (state_q != S_PIXEL || last_bit);
        ld_idx = 7'(idx_d);
        rw     = ram[ld_idx[5:0]];
        if (tick) begin
            bcnt_d = state_q == S_IDLE ? 5'd0 : bcnt_q + 5'd1;
            wcnt_d = state_d != state_q ? 4'd0 : last_bit ? wcnt_q + 4'd1 : wcnt_q;
            sh_d   = ld ? {3'b111, ovr_q ? bri_q : rw[28:24], rw[23:0]} : sh_q << 1;
            data_d = state_d == S_END || (state_d == S_PIXEL && sh_d[31]);
            ck_d   = !(state_d == S_START || state_d == S_PIXEL || state_d == S_END);
        end else if (pre_q == HALF) begin
            ck_d = 1'b1;
        end
        if (!tick) idx_d = idx_q;
    end

    assign unused_bits = ^{wb_dbus_adr[23:9], wb_dbus_adr[1:0], wb_dbus_dat[31:14],
                           wb_dbus_dat[7:3], rw[31:29]};

    always_ff @(posedge wb_clk) begin
        if (ram_we) ram[widx] <= wb_dbus_dat;
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            ack_q   <= 1'b0;
            en_q    <= 1'b0;
            cont_q  <= 1'b0;
            ovr_q   <= 1'b0;
            bri_q   <= '0;
            go_q    <= 1'b0;
            done_q  <= 1'b0;
            pre_q   <= '0;
            state_q <= S_IDLE;
            bcnt_q  <= '0;
            idx_q   <= '0;
            wcnt_q  <= '0;
            sh_q    <= '0;
            ck_q    <= 1'b1;
            data_q  <= 1'b0;
        end else begin
            ack_q   <= ack_d;
            en_q    <= en_d;
            cont_q  <= cont_d;
            ovr_q   <= ovr_d;
            bri_q   <= bri_d;
            go_q    <= go_d;
            done_q  <= done_d;
            pre_q   <= pre_q + 1'b1;
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            idx_q   <= idx_d;
            wcnt_q  <= wcnt_d;
            sh_q    <= sh_d;
            ck_q    <= ck_d;
            data_q  <= data_d;
        end
    end
endmodule

// File: tb/tb_sk9822_chain.sv
// tb_sk9822_chain: directed bench; a bit-stream model of each expected frame is checked at every rising led_ck.
module tb_sk9822_chain;
    localparam logic [31:0] BASE   = 32'h8000_0000;
    localparam logic [31:0] CTRL_A = 32'h8000_0100;
    localparam logic [31:0] STAT_A = 32'h8000_0104;

    logic        clk = 1'b0, rst = 1'b1, cyc = 1'b0, we = 1'b0;
    logic [31:0] adr = '0, dat = '0, rdt;
    logic        ack, led_ck, led_data;

    sk9822_chain #(.ADDR(8'h80), .LEDS(3), .PRESCALE(2), .GAP(1)) dut (
        .wb_clk(clk), .wb_rst(rst), .wb_dbus_cyc(cyc), .wb_dbus_we(we),
        .wb_dbus_adr(adr), .wb_dbus_dat(dat), .wb_dbus_rdt(rdt), .ack(ack),
        .led_ck(led_ck), .led_data(led_data)
    );

    always #5 clk = ~clk;

    typedef struct { logic b; int sp; } exp_t;
    exp_t        exp_q[$];
    exp_t        e_m;
    logic [31:0] rx_words[$];
    logic [31:0] rx_sh;
    logic [31:0] ram_m[3];
    int          rx_n = 0, checks = 0, errors = 0, cyc_n = 0, last_rise = 0, last_fall = 0;
    bit          mon_en = 0, chk_idle = 0;
    logic        ck_prev = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
        end
    endtask

    function automatic logic [31:0] led_word(input logic [31:0] r, input logic [31:0] c);
        return {3'b111, c[13] ? c[12:8] : r[28:24], r[23:0]};
    endfunction

    initial forever @(posedge clk) cyc_n++;

    // Compare process: every rising led_ck must carry the next expected bit at the expected spacing.
    initial forever begin
        @(negedge clk);
        if (mon_en) begin
            if (!led_ck && ck_prev) last_fall = cyc_n;
            if (led_ck && !ck_prev) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_bit: data %0b at cycle %0d, none expected", led_data, cyc_n);
                end else begin
                    e_m = exp_q.pop_front();
                    chk("bit", {31'd0, led_data}, {31'd0, e_m.b});
                    chk("ck_low", cyc_n - last_fall, 2);
                    if (e_m.sp != 0) chk("spacing", cyc_n - last_rise, e_m.sp);
                end
                last_rise = cyc_n;
                rx_sh = {rx_sh[30:0], led_data};
                rx_n++;
                if (rx_n == 32) begin
                    rx_words.push_back(rx_sh);
                    rx_n = 0;
                end
            end
            if (chk_idle) begin
                chk("idle_ck", {31'd0, led_ck}, 1);
                chk("idle_data", {31'd0, led_data}, 0);
            end
        end
        ck_prev = led_ck;
    end

    task automatic bus(input logic [31:0] a, input logic w, input logic [31:0] d, output logic [31:0] r);
        bit got = 0;
        r = '0;
        @(negedge clk);
        cyc = 1'b1; we = w; adr = a; dat = d;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clk); #1;
            if (ack) begin got = 1; r = rdt; end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: no ack for address 0x%08h", a);
        end
        @(posedge clk); #1;
        chk("ack_single", {31'd0, ack}, 0);
        cyc = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] r;
        if (!a[8] && a[7:2] < 3) ram_m[a[3:2]] = d;
        bus(a, 1'b1, d, r);
    endtask

    task automatic rdchk(input string name, input logic [31:0] a, input logic [31:0] expv);
        logic [31:0] r;
        bus(a, 1'b0, '0, r);
        chk(name, r, expv);
    endtask

    task automatic push_frame(input int sp, input logic [31:0] c);
        logic [31:0] w;
        for (int i = 0; i < 32; i++) exp_q.push_back('{b: 1'b0, sp: (i == 0) ? sp : 4});
        for (int l = 0; l < 3; l++) begin
            w = led_word(ram_m[l], c);
            for (int i = 31; i >= 0; i--) exp_q.push_back('{b: w[i], sp: 4});
        end
        for (int i = 0; i < 32; i++) exp_q.push_back('{b: 1'b1, sp: 4});
    endtask

    task automatic wait_rem(input int n, input int budget);
        for (int i = 0; i < budget && exp_q.size() > n; i++) @(posedge clk);
        chk("wait_bound", {31'd0, exp_q.size() > n}, 0);
    endtask

    task automatic idle(input int n);
        repeat (8) @(posedge clk);
        chk_idle = 1;
        repeat (n) @(posedge clk);
        chk_idle = 0;
    endtask

    task automatic rx_clear();
        rx_words.delete();
        rx_n = 0;
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (4) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        wr(BASE, 32'h1234_5678);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_ck", {31'd0, led_ck}, 1);
        chk("rst_data", {31'd0, led_data}, 0);
        chk("rst_ack", {31'd0, ack}, 0);
        chk("rst_rdt", rdt, 0);
        rst = 1'b0;
        mon_en = 1;
        rdchk("rst_status", STAT_A, 0);
        rdchk("rst_ctrl", CTRL_A, 0);
        rdchk("ram_kept", BASE, 32'h1234_5678);

        wr(BASE, 32'h1F00_00FF);
        wr(BASE + 4, 32'h0100_FF00);
        wr(BASE + 8, 32'h02FF_0000);
        rdchk("ram1_rb", BASE + 4, 32'h0100_FF00);
        rx_clear();
        push_frame(0, 32'h5);
        wr(CTRL_A, 32'h5);
        wait_rem(0, 2000);
        chk("rx_count", rx_words.size(), 5);
        chk("start_frame", rx_words[0], 32'h0000_0000);
        chk("led0", rx_words[1], 32'hFF00_00FF);
        chk("led1", rx_words[2], 32'hE100_FF00);
        chk("led2", rx_words[3], 32'hE2FF_0000);
        chk("end_frame", rx_words[4], 32'hFFFF_FFFF);
        idle(60);
        rdchk("status_done", STAT_A, 32'h2);
        rdchk("ctrl_go_reads0", CTRL_A, 32'h1);
        wr(STAT_A, 32'h2);
        rdchk("status_cleared", STAT_A, 32'h0);

        rx_clear();
        push_frame(0, 32'h2505);
        wr(CTRL_A, 32'h2505);
        wait_rem(0, 2000);
        chk("ovr_led0", rx_words[1], 32'hE500_00FF);
        chk("ovr_led2", rx_words[3], 32'hE5FF_0000);
        wr(CTRL_A, 32'h0);

        rx_clear();
        push_frame(0, 32'h3);
        push_frame(132, 32'h3);
        wr(CTRL_A, 32'h3);
        wait_rem(100, 3000);
        wr(CTRL_A, 32'h0);
        rdchk("status_busy", STAT_A, 32'h3);
        wait_rem(0, 2000);
        idle(900);
        chk("cont_rx_count", rx_words.size(), 10);
        chk("cont_start2", rx_words[5], 32'h0);
        chk("cont_led0_2", rx_words[6], 32'hFF00_00FF);

        begin
            int n = 0;
            @(negedge clk);
            cyc = 1'b1; adr = 32'h0100_0104;
            repeat (20) begin
                @(posedge clk); #1;
                if (ack) n++;
            end
            cyc = 1'b0;
            chk("miss_no_ack", n, 0);
        end
        wr(BASE + 20, 32'hDEAD_BEEF);
        rdchk("oob_read", BASE + 20, 32'h0);
        wr(BASE | 32'h10C, 32'hFFFF_FFFF);
        rdchk("unmapped_read", BASE | 32'h10C, 32'h0);
        rdchk("status_done2", STAT_A, 32'h2);
        wr(STAT_A, 32'h2);
        rdchk("status_clr2", STAT_A, 32'h0);

        mon_en = 0;
        wr(CTRL_A, 32'h5);
        repeat (250) @(posedge clk);
        rdchk("busy_mid", STAT_A, 32'h1);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_ck", {31'd0, led_ck}, 1);
        chk("midrst_data", {31'd0, led_data}, 0);
        rst = 1'b0;
        rdchk("midrst_status", STAT_A, 32'h0);
        rdchk("midrst_ctrl", CTRL_A, 32'h0);
        rx_clear();
        mon_en = 1;
        push_frame(0, 32'h5);
        push_frame(8, 32'h5);
        wr(CTRL_A, 32'h5);
        repeat (20) @(posedge clk);
        wr(CTRL_A, 32'h5);
        wr(CTRL_A, 32'h5);
        wait_rem(0, 3000);
        idle(900);
        chk("go_rx_count", rx_words.size(), 10);
        chk("go_start", rx_words[0], 32'h0);
        chk("go_led2", rx_words[8], 32'hE2FF_0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
